// File: rtl/fifo_pkg.sv
// Shared helpers for the tagged FIFO family: sizing and tag placement.
// Both the merge and demux blocks use these, so the tag sits in the same bits in each.
package fifo_pkg;

  // Number of bits needed to index v items.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Place a tag above a pw-bit payload.
  // The payload must already be confined to its pw bits.
  function automatic logic [31:0] tag_insert(input logic [31:0] tag,
                                             input logic [31:0] payload,
                                             input int unsigned pw);
    return (tag << pw) | payload;
  endfunction

  // Recover the tag from a tagged word with a pw-bit payload.
  function automatic logic [31:0] tag_extract(input logic [31:0] word,
                                              input int unsigned pw);
    return word >> pw;
  endfunction

endpackage

// File: rtl/fifo_merge_tagged_if.sv
// Producer/consumer bundle of the tagged merge FIFO.
// The master modport is the environment side; the slave modport is the FIFO side.
interface fifo_merge_tagged_if
  import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = clog2(FLUX),
    parameter int PW        = WIDTH - TAG_WIDTH
);
    logic [FLUX-1:0]    wr;
    logic [FLUX*PW-1:0] datain;
    logic [FLUX-1:0]    full;
    logic [FLUX-1:0]    empty;
    logic [FLUX-1:0]    overflow;
    logic               rd;
    logic               valid;
    logic [WIDTH-1:0]   dataout;

    modport master (output wr, datain, rd,
                    input  full, empty, overflow, valid, dataout);
    modport slave  (input  wr, datain, rd,
                    output full, empty, overflow, valid, dataout);
endinterface

// File: rtl/fifo_merge_tagged_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last grant, wrapping.
// The last-grant register resets to FLUX-1, so requester 0 wins first.
module rr_arbiter #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = 1
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic [FLUX-1:0]      req,
    input  logic                 en,
    output logic [TAG_WIDTH-1:0] grant,
    output logic                 grant_valid
);
    logic [TAG_WIDTH-1:0] last;

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= FLUX; k++) begin
            int idx;
            idx = (int'(last) + k) % FLUX;
            if (en && !grant_valid && req[idx]) begin
                grant       = TAG_WIDTH'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge ck or posedge rst) begin
        if (rst)              last <= TAG_WIDTH'(FLUX - 1);
        else if (grant_valid) last <= grant;
    end
endmodule

// File: rtl/fifo_merge_tagged.sv
// FLUX private FIFOs merged round-robin into one registered stream.
// The source index is carried in the tag bits of each output word.
module fifo_merge_tagged
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = clog2(FLUX),
    parameter int PW        = WIDTH - TAG_WIDTH
) (
    input logic                ck,
    input logic                rst,
    fifo_merge_tagged_if.slave bus
);
    localparam int AW = clog2(DEPTH);

    logic [FLUX*PW-1:0]   head_flat;
    logic [PW-1:0]        head_sel;
    logic [FLUX-1:0]      req;
    logic                 load;
    logic                 grant_valid;
    logic [TAG_WIDTH-1:0] grant;

    // The output register takes a new word when empty or while the current one is accepted.
    assign load = ~bus.valid | bus.rd;

    for (genvar i = 0; i < FLUX; i++) begin : g_flux
        logic [PW-1:0] mem [DEPTH];
        logic [AW-1:0] wp;
        logic [AW-1:0] rp;
        logic [AW:0]   count;
        logic          push;
        logic          pop;

        // full comes from the pre-edge count, so a write to a full flux is dropped even if it pops this cycle.
        assign push = bus.wr[i] & ~bus.full[i];
        assign pop  = grant_valid & (int'(grant) == i);

        // NOTE: storage is left unreset; pointers and count alone decide what is valid.
        always_ff @(posedge ck) begin
            if (push) mem[wp] <= bus.datain[i*PW +: PW];
        end

        always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop)  rp <= rp + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end

        assign bus.full[i]              = (count == (AW + 1)'(DEPTH));
        assign bus.empty[i]             = (count == '0);
        assign req[i]                   = ~bus.empty[i];
        assign head_flat[i*PW +: PW]    = mem[rp];
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) bus.overflow <= '0;
        else     bus.overflow <= bus.overflow | (bus.wr & bus.full);
    end

    rr_arbiter #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_arb (
        .ck          (ck),
        .rst         (rst),
        .req         (req),
        .en          (load),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign head_sel = head_flat[int'(grant)*PW +: PW];

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            bus.valid   <= 1'b0;
            bus.dataout <= '0;
        end else if (grant_valid) begin
            bus.valid   <= 1'b1;
            bus.dataout <= WIDTH'(tag_insert(32'(grant), 32'(head_sel), PW));
        end else if (load) begin
            bus.valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_merge_tagged.sv
// Bench for fifo_merge_tagged: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_merge_tagged;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int FLUX  = 2;
    localparam int PW    = 7;

    logic ck;
    logic rst;
    int   checks;
    int   errors;

    fifo_merge_tagged_if #(.WIDTH(WIDTH), .FLUX(FLUX)) bus ();

    fifo_merge_tagged #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FLUX  (FLUX)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: per-flux word queues plus the presented output word.
    logic [PW-1:0]    q [FLUX][$];
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_last;
    logic [FLUX-1:0]  m_ovf;

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) q[i].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_last  = FLUX - 1;
            m_ovf   = '0;
        end else begin
            logic [FLUX-1:0] was_full;
            int g;
            for (int i = 0; i < FLUX; i++) was_full[i] = (q[i].size() == DEPTH);
            if (!m_valid || bus.rd) begin
                g = -1;
                for (int k = 1; k <= FLUX; k++) begin
                    int idx;
                    idx = (m_last + k) % FLUX;
                    if (g < 0 && q[idx].size() > 0) g = idx;
                end
                if (g >= 0) begin
                    m_data  = WIDTH'(g * (1 << PW)) | WIDTH'(q[g].pop_front());
                    m_valid = 1'b1;
                    m_last  = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < FLUX; i++) begin
                if (bus.wr[i]) begin
                    if (was_full[i]) m_ovf[i] = 1'b1;
                    else             q[i].push_back(bus.datain[i*PW +: PW]);
                end
            end
        end
    end

    always @(negedge ck) begin
        if (!rst) begin
            logic [FLUX-1:0] e_full;
            logic [FLUX-1:0] e_empty;
            for (int i = 0; i < FLUX; i++) begin
                e_full[i]  = (q[i].size() == DEPTH);
                e_empty[i] = (q[i].size() == 0);
            end
            check("model_valid", 32'(bus.valid), 32'(m_valid));
            if (m_valid) check("model_dataout", 32'(bus.dataout), 32'(m_data));
            check("model_full", 32'(bus.full), 32'(e_full));
            check("model_empty", 32'(bus.empty), 32'(e_empty));
            check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // Apply inputs, let one rising edge pass, return 1 time unit after it.
    task automatic cyc(input logic [1:0] w, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                       input logic r);
        bus.wr     = w;
        bus.datain = {p1, p0};
        bus.rd     = r;
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        bus.wr     = '0;
        bus.datain = '0;
        bus.rd     = 1'b0;
        rst        = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        @(posedge ck);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.wr     = '0;
        bus.datain = '0;
        bus.rd     = 1'b0;
        #2;
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_dataout", 32'(bus.dataout), 32'h0);
        check("reset_empty", 32'(bus.empty), 32'h3);
        check("reset_full", 32'(bus.full), 32'h0);
        check("reset_overflow", 32'(bus.overflow), 32'h0);
        do_reset();

        // Single word: written at one edge, presented after the next.
        cyc(2'b01, 7'h15, 7'h00, 1'b1);
        check("t1_no_bypass", 32'(bus.valid), 32'h0);
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t1_valid", 32'(bus.valid), 32'h1);
        check("t1_data", 32'(bus.dataout), 32'h15);
        check("t1_empty", 32'(bus.empty), 32'h3);
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t1_drained", 32'(bus.valid), 32'h0);

        // Simultaneous writes to both fluxes: flux 0 first, then tagged flux 1.
        do_reset();
        cyc(2'b11, 7'h11, 7'h2A, 1'b1);
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t2_first", 32'(bus.dataout), 32'h11);
        check("t2_first_valid", 32'(bus.valid), 32'h1);
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t2_second", 32'(bus.dataout), 32'hAA);
        check("t2_second_valid", 32'(bus.valid), 32'h1);
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t2_idle", 32'(bus.valid), 32'h0);

        // Fill flux 0 behind a held output word, then overflow it.
        do_reset();
        for (int k = 1; k <= 5; k++) cyc(2'b01, PW'(k), 7'h00, 1'b0);
        check("t3_full", 32'(bus.full), 32'h1);
        check("t3_no_ovf_yet", 32'(bus.overflow), 32'h0);
        cyc(2'b01, 7'h06, 7'h00, 1'b0);
        check("t3_overflow", 32'(bus.overflow), 32'h1);
        check("t3_still_full", 32'(bus.full), 32'h1);
        check("t3_head", 32'(bus.dataout), 32'h01);
        for (int k = 2; k <= 5; k++) begin
            cyc(2'b00, 7'h00, 7'h00, 1'b1);
            check("t3_drain", 32'(bus.dataout), 32'(k));
        end
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t3_drained", 32'(bus.valid), 32'h0);
        check("t3_ovf_sticky", 32'(bus.overflow), 32'h1);

        // Fairness: three words per flux, tags alternate.
        do_reset();
        cyc(2'b11, 7'h10, 7'h20, 1'b0);
        cyc(2'b11, 7'h11, 7'h21, 1'b0);
        cyc(2'b11, 7'h12, 7'h22, 1'b0);
        check("t4_head", 32'(bus.dataout), 32'h10);
        begin
            logic [7:0] exp_seq [5];
            exp_seq = '{8'hA0, 8'h11, 8'hA1, 8'h12, 8'hA2};
            for (int k = 0; k < 5; k++) begin
                cyc(2'b00, 7'h00, 7'h00, 1'b1);
                check("t4_rr", 32'(bus.dataout), 32'(exp_seq[k]));
            end
        end
        check("t4_empty", 32'(bus.empty), 32'h3);
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t4_done", 32'(bus.valid), 32'h0);

        // Backpressure: output held while writes keep arriving.
        do_reset();
        cyc(2'b01, 7'h30, 7'h00, 1'b0);
        cyc(2'b01, 7'h31, 7'h00, 1'b0);
        check("t5_hold", 32'(bus.dataout), 32'h30);
        for (int k = 2; k <= 4; k++) begin
            cyc(2'b01, PW'(8'h30 + k), 7'h00, 1'b0);
            check("t5_hold", 32'(bus.dataout), 32'h30);
        end
        cyc(2'b10, 7'h00, 7'h40, 1'b0);
        check("t5_hold", 32'(bus.dataout), 32'h30);
        check("t5_hold_valid", 32'(bus.valid), 32'h1);
        check("t5_full", 32'(bus.full), 32'h1);
        begin
            logic [7:0] exp_seq [5];
            exp_seq = '{8'hC0, 8'h31, 8'h32, 8'h33, 8'h34};
            for (int k = 0; k < 5; k++) begin
                cyc(2'b00, 7'h00, 7'h00, 1'b1);
                check("t5_order", 32'(bus.dataout), 32'(exp_seq[k]));
            end
        end
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t5_done", 32'(bus.valid), 32'h0);

        // Asynchronous reset with words queued, output valid and overflow set.
        do_reset();
        for (int k = 0; k < 6; k++) cyc(2'b01, PW'(8'h50 + k), 7'h00, 1'b0);
        check("t6_pre_valid", 32'(bus.valid), 32'h1);
        check("t6_pre_ovf", 32'(bus.overflow), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(bus.valid), 32'h0);
        check("t6_empty", 32'(bus.empty), 32'h3);
        check("t6_full", 32'(bus.full), 32'h0);
        check("t6_overflow", 32'(bus.overflow), 32'h0);
        do_reset();
        cyc(2'b10, 7'h00, 7'h05, 1'b1);
        cyc(2'b00, 7'h00, 7'h00, 1'b1);
        check("t6_after", 32'(bus.dataout), 32'h85);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
